// File: rtl/cnn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : cnn_pkg                                                      |
// | Description : Shared types and helpers for the binary conv datapath:       |
// |               accumulator FSM state encoding, accumulator width rule and   |
// |               a generic sign-extension helper.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cnn_pkg;

  // ACCUM collects beats of the current window; HOLD presents a finished sum.
  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  // Working width of the sign-extension helper; accumulators wider than this
  // are not supported by sign_extend().
  localparam int c_sext_width = 64;

  // Width that holds KERNEL_SIZE worst-case products without wrapping.
  function automatic int acc_width(input int bits, input int k);
    return bits + $clog2(k);
  endfunction

  // Treats the low 'bits' bits of 'value' as two's complement and returns
  // them sign-extended to the full helper width. Callers truncate the result
  // to their own width.
  function automatic logic [c_sext_width-1:0] sign_extend(
    input logic [c_sext_width-1:0] value,
    input int                      bits
  );
    logic signed [c_sext_width-1:0] v;
    v = signed'(value << (c_sext_width - bits));
    return v >>> (c_sext_width - bits);
  endfunction

endpackage
`default_nettype wire

// File: rtl/binary_mac_accumulator_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : binary_mac_accumulator_if                                    |
// | Description : Product input stream, window-sum output stream and the       |
// |               synchronous partial-window abort of the MAC accumulator.     |
// |               master = upstream/downstream environment, slave = block.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface binary_mac_accumulator_if
  import cnn_pkg::*;
#(
  parameter int BIT_SIZE = 32,
  parameter int ACC_SIZE = acc_width(BIT_SIZE, 9)
) ();

  logic                i_clear;
  logic [BIT_SIZE-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic [ACC_SIZE-1:0] out_data;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output i_clear,
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  i_clear,
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );

endinterface
`default_nettype wire

// File: rtl/kernel_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : kernel_counter                                               |
// | Description : Beat position within a window, counting 0..KERNEL_SIZE-1.   |
// |               Wraps to 0 after the last beat; synchronous clear wins over  |
// |               increment. Flags the first and the last beat position.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module kernel_counter #(
  parameter int KERNEL_SIZE = 9
) (
  input  wire logic clk,
  input  wire logic res_n,
  input  wire logic i_clear,
  input  wire logic i_inc,
  output logic      o_first,
  output logic      o_last
);

  // A one-beat window still needs a 1-bit register to stay legal.
  localparam int c_cnt_width = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam logic [c_cnt_width-1:0] c_last_value = c_cnt_width'(KERNEL_SIZE - 1);
  localparam logic [c_cnt_width-1:0] c_one        = c_cnt_width'(1);

  logic [c_cnt_width-1:0] r_count;

  // Position counter: clear aborts the window, otherwise advance and wrap.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= o_last ? '0 : (r_count + c_one);
    end
  end

  assign o_first = (r_count == '0);
  assign o_last  = (r_count == c_last_value);

endmodule
`default_nettype wire

// File: rtl/binary_mac_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : binary_mac_accumulator                                       |
// | Description : Sums KERNEL_SIZE signed +/-1-weight products per window and  |
// |               presents each window sum on a valid/ready output. A new      |
// |               window may start in the same cycle the previous sum is       |
// |               consumed, so back-to-back windows have no bubble.            |
// |               Build option: define BMAC_RELU_EN to clamp negative window   |
// |               sums to zero when they are loaded into the output register.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module binary_mac_accumulator
  import cnn_pkg::*;
#(
  parameter int BIT_SIZE    = 32,
  parameter int KERNEL_SIZE = 9,
  // Must be >= BIT_SIZE and <= 64; the default is just wide enough for
  // KERNEL_SIZE worst-case products of either sign.
  parameter int ACC_SIZE    = acc_width(BIT_SIZE, KERNEL_SIZE)
) (
  input  wire logic               clk,
  input  wire logic               res_n,
  binary_mac_accumulator_if.slave bus
);

  acc_state_t          r_state;
  acc_state_t          w_next_state;
  logic [ACC_SIZE-1:0] r_acc;
  logic [ACC_SIZE-1:0] r_out_data;
  logic [ACC_SIZE-1:0] w_term;
  logic [ACC_SIZE-1:0] w_sum;
  logic [ACC_SIZE-1:0] w_result;
  logic                w_in_ready;
  logic                w_beat;
  logic                w_load_out;
  logic                w_first;
  logic                w_last;

  // While a sum is held, input is only taken in the cycle that sum is
  // consumed, which is what lets the next window start without a bubble.
  assign w_in_ready = (r_state == ACCUM) || bus.out_ready;

  // A beat counts only when handshaken and not cancelled by a clear.
  assign w_beat = bus.in_valid && w_in_ready && !bus.i_clear;

  // Product sign-extended to accumulator width.
  assign w_term = ACC_SIZE'(sign_extend(c_sext_width'(bus.in_data), BIT_SIZE));

  // First beat of a window restarts the sum instead of adding to stale data.
  assign w_sum = (w_first ? '0 : r_acc) + w_term;

`ifdef BMAC_RELU_EN
  // Negative window sums leave the block as zero.
  assign w_result = w_sum[ACC_SIZE-1] ? '0 : w_sum;
`else
  assign w_result = w_sum;
`endif

  kernel_counter #(
    .KERNEL_SIZE (KERNEL_SIZE)
  ) u_kernel_counter (
    .clk     (clk),
    .res_n   (res_n),
    .i_clear (bus.i_clear),
    .i_inc   (w_beat),
    .o_first (w_first),
    .o_last  (w_last)
  );

  // Next-state and output-load decode.
  always_comb begin
    w_next_state = r_state;
    w_load_out   = 1'b0;
    case (r_state)
      ACCUM: begin
        if (w_beat && w_last) begin
          w_load_out   = 1'b1;
          w_next_state = HOLD;
        end
      end
      HOLD: begin
        // Any beat taken here implies out_ready, so the held sum is gone.
        // With a one-beat window that beat is itself a finished sum.
        if (bus.out_ready) begin
          if (w_beat && w_last) begin
            w_load_out   = 1'b1;
            w_next_state = HOLD;
          end else begin
            w_next_state = ACCUM;
          end
        end
      end
      default: begin
        w_next_state = ACCUM;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Running window sum; a clear abandons the partial window.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_acc <= '0;
    end else if (bus.i_clear) begin
      r_acc <= '0;
    end else if (w_beat) begin
      r_acc <= w_sum;
    end
  end

  // Output register captures the completed window sum; stable while held.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_out_data <= '0;
    end else if (w_load_out) begin
      r_out_data <= w_result;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = (r_state == HOLD);

endmodule
`default_nettype wire

// File: tb/tb_binary_mac_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_binary_mac_accumulator                                    |
// | Description : Directed self-checking bench. Three instances: 8-bit         |
// |               products with windows of 9, 4 and 3 beats. Inputs change and |
// |               outputs are sampled on the falling clock edge.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_binary_mac_accumulator;

  logic clk;
  logic res_n;

  int checks = 0;
  int errors = 0;

  binary_mac_accumulator_if #(.BIT_SIZE(8), .ACC_SIZE(12)) bus9 ();
  binary_mac_accumulator_if #(.BIT_SIZE(8), .ACC_SIZE(10)) bus4 ();
  binary_mac_accumulator_if #(.BIT_SIZE(8), .ACC_SIZE(10)) bus3 ();

  binary_mac_accumulator #(.BIT_SIZE(8), .KERNEL_SIZE(9), .ACC_SIZE(12)) dut9 (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus9)
  );

  binary_mac_accumulator #(.BIT_SIZE(8), .KERNEL_SIZE(4), .ACC_SIZE(10)) dut4 (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus4)
  );

  binary_mac_accumulator #(.BIT_SIZE(8), .KERNEL_SIZE(3), .ACC_SIZE(10)) dut3 (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] actual,
                       input logic signed [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // One beat into the 3-beat instance, applied at the next falling edge.
  task automatic drive3(input int v);
    @(negedge clk);
    bus3.i_clear  = 1'b0;
    bus3.in_valid = 1'b1;
    bus3.in_data  = 8'(v);
  endtask

  // Stop driving the 3-beat instance at the next falling edge.
  task automatic idle3();
    @(negedge clk);
    bus3.i_clear  = 1'b0;
    bus3.in_valid = 1'b0;
  endtask

  // Safety net in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got no end of test, expected end before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    int vals3[6];
    vals3 = '{5, -2, 1, 3, 3, 3};

    res_n = 1'b0;
    bus9.i_clear = 1'b0; bus9.in_valid = 1'b0; bus9.in_data = '0; bus9.out_ready = 1'b1;
    bus4.i_clear = 1'b0; bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b1;
    bus3.i_clear = 1'b0; bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.out_ready = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_out_valid", 64'(bus9.out_valid), 0);
    check("rst_out_data", $signed(bus9.out_data), 0);
    check("rst_in_ready", 64'(bus9.in_ready), 1);
    check("rst_out_valid3", 64'(bus3.out_valid), 0);
    res_n = 1'b1;

    // Nine +1 products: sum 9, valid one cycle after the ninth beat, one pulse.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 8) check("k9_no_early_valid", 64'(bus9.out_valid), 0);
      bus9.in_valid = 1'b1;
      bus9.in_data  = 8'd1;
    end
    @(negedge clk);
    bus9.in_valid = 1'b0;
    check("k9_valid", 64'(bus9.out_valid), 1);
    check("k9_sum", $signed(bus9.out_data), 9);
    @(negedge clk);
    check("k9_single_pulse", 64'(bus9.out_valid), 0);

    // Four most-negative products: -512 fits exactly in 10 bits.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus4.in_valid = 1'b1;
      bus4.in_data  = 8'h80;
    end
    @(negedge clk);
    bus4.in_valid = 1'b0;
    check("k4_valid", 64'(bus4.out_valid), 1);
`ifdef BMAC_RELU_EN
    check("k4_min_sum_relu", $signed(bus4.out_data), 0);
`else
    check("k4_min_sum", $signed(bus4.out_data), -512);
`endif
    @(negedge clk);
    check("k4_valid_drop", 64'(bus4.out_valid), 0);

    // Back-to-back windows {5,-2,1},{3,3,3}: 4 then 9, input never stalls.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("k3_b2b_in_ready", 64'(bus3.in_ready), 1);
      if (i == 3) begin
        check("k3_b2b_valid1", 64'(bus3.out_valid), 1);
        check("k3_b2b_sum1", $signed(bus3.out_data), 4);
      end
      bus3.in_valid = 1'b1;
      bus3.in_data  = 8'(vals3[i]);
    end
    idle3();
    check("k3_b2b_valid2", 64'(bus3.out_valid), 1);
    check("k3_b2b_sum2", $signed(bus3.out_data), 9);
    @(negedge clk);
    check("k3_b2b_idle", 64'(bus3.out_valid), 0);

    // Back-pressure: sum 4 held for five cycles with input blocked.
    drive3(5); drive3(-2); drive3(1);
    @(negedge clk);
    bus3.out_ready = 1'b0;
    bus3.in_valid  = 1'b1;
    bus3.in_data   = 8'd7;
    #1;
    check("bp_in_ready", 64'(bus3.in_ready), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(bus3.out_valid), 1);
      check("bp_hold_data", $signed(bus3.out_data), 4);
      check("bp_hold_in_ready", 64'(bus3.in_ready), 0);
    end
    @(negedge clk);
    bus3.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 64'(bus3.in_ready), 1);
    @(negedge clk);
    check("bp_consumed", 64'(bus3.out_valid), 0);
    drive3(7);
    idle3();
    check("bp_next_valid", 64'(bus3.out_valid), 1);
    check("bp_next_sum", $signed(bus3.out_data), 21);

    // Clear after two beats drops the partial window.
    drive3(2); drive3(2);
    @(negedge clk);
    bus3.in_valid = 1'b0;
    bus3.i_clear  = 1'b1;
    drive3(1); drive3(1); drive3(1);
    idle3();
    check("clr_valid", 64'(bus3.out_valid), 1);
    check("clr_sum", $signed(bus3.out_data), 3);

    // Clear coinciding with a beat: that beat is discarded too.
    drive3(4);
    @(negedge clk);
    bus3.i_clear  = 1'b1;
    bus3.in_valid = 1'b1;
    bus3.in_data  = 8'd50;
    drive3(1); drive3(1); drive3(1);
    idle3();
    check("clr_beat_valid", 64'(bus3.out_valid), 1);
    check("clr_beat_sum", $signed(bus3.out_data), 3);

    // Reset mid-window: outputs return to reset values, partial sum lost.
    drive3(9); drive3(9);
    @(negedge clk);
    bus3.in_valid = 1'b0;
    res_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(bus3.out_valid), 0);
    check("rst_mid_data", $signed(bus3.out_data), 0);
    check("rst_mid_in_ready", 64'(bus3.in_ready), 1);
    check("rst_mid_data9", $signed(bus9.out_data), 0);
    @(negedge clk);
    res_n = 1'b1;
    drive3(2); drive3(2);
    @(negedge clk);
    check("rst_mid_no_output", 64'(bus3.out_valid), 0);
    bus3.in_valid = 1'b1;
    bus3.in_data  = 8'd2;
    idle3();
    check("rst_after_valid", 64'(bus3.out_valid), 1);
    check("rst_after_sum", $signed(bus3.out_data), 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
